// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-based instruction prefetcher with in-order response queue and flush.
// Optional IFU_PREFETCH_PERF_EN adds a 32-bit drop_count output counting discarded responses.
module ifu_prefetch #(
  parameter int DEPTH                = 4,
  parameter int FETCH_STRIDE         = 4,
  parameter int XLEN                 = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 16,
  parameter int INSTR_MEM_WIDTH      = 32,
  parameter int INSTR_MEM_TAG_WIDTH  = 32,
  parameter int INSTR_LEN            = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [XLEN-1:0]                 reset_vector,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_mem_addr,
  output logic                            instr_mem_addr_valid,
  output logic [XLEN-1:0]                 instr_mem_tag_out,
  input  logic [INSTR_MEM_WIDTH-1:0]      instr_mem_rdata,
  input  logic                            instr_mem_rdata_valid,
  input  logic [INSTR_MEM_TAG_WIDTH-1:0]  instr_mem_tag_in,
  input  logic [XLEN-1:0]                 pc_exu,
  input  logic                            pc_load,
  input  logic                            pipe_stall,
  output logic [INSTR_LEN-1:0]            instr,
  output logic                            instr_valid,
  output logic [XLEN-1:0]                 instr_tag
`ifdef IFU_PREFETCH_PERF_EN
  ,output logic [31:0]                    drop_count
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [CW-1:0]        out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [INSTR_LEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0]      tag_mem  [DEPTH];
  logic                 issue, dropping, push, pop;

  // Credits count both in-flight requests and queued entries, so the queue can never overflow.
  assign issue    = rst_n & ~pc_load & (({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(DEPTH));
  assign dropping = drop_q != '0;
  assign push     = instr_mem_rdata_valid & ~dropping & ~pc_load;
  assign pop      = (cnt_q != '0) & ~pipe_stall & ~pc_load;

  always_comb begin
    pc_d   = pc_load ? pc_exu : (issue ? pc_q + XLEN'(FETCH_STRIDE) : pc_q);
    out_d  = out_q + CW'(issue) - CW'(instr_mem_rdata_valid);
    drop_d = pc_load ? out_q - CW'(instr_mem_rdata_valid)
                     : drop_q - CW'(instr_mem_rdata_valid & dropping);
    cnt_d  = pc_load ? '0 : cnt_q + CW'(push) - CW'(pop);
    head_d = pc_load ? '0 : head_q + AW'(pop);
    tail_d = pc_load ? '0 : tail_q + AW'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= reset_vector;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail_q] <= instr_mem_rdata[INSTR_LEN-1:0];
      tag_mem[tail_q]  <= instr_mem_tag_in[XLEN-1:0];
    end
  end

  assign instr_mem_addr       = pc_q[INSTR_MEM_ADDR_WIDTH-1:0];
  assign instr_mem_addr_valid = issue;
  assign instr_mem_tag_out    = pc_q;
  assign instr_valid          = cnt_q != '0;
  // Outputs are forced to zero when empty so stale entries never leak out.
  assign instr                = instr_valid ? data_mem[head_q] : '0;
  assign instr_tag            = instr_valid ? tag_mem[head_q] : '0;

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] drop_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count_q <= '0;
    else if (instr_mem_rdata_valid & (pc_load | dropping)) drop_count_q <= drop_count_q + 32'd1;
  end
  assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenario bench for ifu_prefetch with an in-order fixed-latency memory model.
module tb_ifu_prefetch;
  logic        clk = 0, rst_n = 0;
  logic [31:0] reset_vector = 32'h1000, pc_exu = 0, rdata = 0, tag_in = 0;
  logic        rdata_valid = 0, pc_load = 0, pipe_stall = 0;
  logic [15:0] addr;
  logic        addr_valid, instr_valid;
  logic [31:0] tag_out, instr, instr_tag;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] drop_count;
`endif

  int tests = 0, fails = 0, lat = 1, cyc = 0;
  logic [31:0] mq_tag[$], req_log[$], out_log[$], dat_log[$];
  int          mq_due[$];

  ifu_prefetch dut (
    .clk(clk), .rst_n(rst_n), .reset_vector(reset_vector),
    .instr_mem_addr(addr), .instr_mem_addr_valid(addr_valid), .instr_mem_tag_out(tag_out),
    .instr_mem_rdata(rdata), .instr_mem_rdata_valid(rdata_valid), .instr_mem_tag_in(tag_in),
    .pc_exu(pc_exu), .pc_load(pc_load), .pipe_stall(pipe_stall),
    .instr(instr), .instr_valid(instr_valid), .instr_tag(instr_tag)
`ifdef IFU_PREFETCH_PERF_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dfn(input logic [31:0] t);
    return t ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model and monitor: sample pre-edge values on posedge, drive responses on negedge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      mq_tag.delete();
      mq_due.delete();
    end else begin
      if (rdata_valid) begin
        void'(mq_tag.pop_front());
        void'(mq_due.pop_front());
      end
      if (addr_valid) begin
        mq_tag.push_back(tag_out);
        mq_due.push_back(cyc + lat);
        req_log.push_back(tag_out);
      end
      if (instr_valid && !pipe_stall && !pc_load) begin
        out_log.push_back(instr_tag);
        dat_log.push_back(instr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mq_tag.size() > 0 && mq_due[0] <= cyc) begin
      rdata_valid = 1; tag_in = mq_tag[0]; rdata = dfn(mq_tag[0]);
    end else begin
      rdata_valid = 0; tag_in = 0; rdata = 0;
    end
  end

  task automatic do_reset(input logic [31:0] vec);
    @(negedge clk);
    rst_n = 0; pc_load = 0; pipe_stall = 0; pc_exu = 0; reset_vector = vec;
    repeat (2) @(negedge clk);
    req_log.delete(); out_log.delete(); dat_log.delete();
    rst_n = 1;
  endtask

  task automatic test_reset();
    lat = 1;
    @(negedge clk);
    rst_n = 0; reset_vector = 32'h1000;
    #1;
    tests++; if (addr_valid !== 1'b0) begin fails++; $display("FAIL reset_addr_valid: got %b want 0", addr_valid); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
    tests++; if (instr_tag !== 32'h0) begin fails++; $display("FAIL reset_instr_tag: got %h want 0", instr_tag); end
    do_reset(32'h1000);
    #1;
    tests++; if (addr_valid !== 1'b1) begin fails++; $display("FAIL first_req_valid: got %b want 1", addr_valid); end
    tests++; if (tag_out !== 32'h1000) begin fails++; $display("FAIL first_req_tag: got %h want 00001000", tag_out); end
    tests++; if (addr !== 16'h1000) begin fails++; $display("FAIL first_req_addr: got %h want 1000", addr); end
  endtask

  task automatic test_stream();
    lat = 1;
    do_reset(32'h1000);
    repeat (14) @(negedge clk);
    tests++; if (out_log.size() != 12) begin fails++; $display("FAIL stream_count: got %0d want 12", out_log.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (req_log[i] !== 32'h1000 + 32'(4*i)) begin fails++; $display("FAIL stream_req[%0d]: got %h want %h", i, req_log[i], 32'h1000 + 32'(4*i)); end
      tests++; if (out_log[i] !== 32'h1000 + 32'(4*i)) begin fails++; $display("FAIL stream_tag[%0d]: got %h want %h", i, out_log[i], 32'h1000 + 32'(4*i)); end
      tests++; if (dat_log[i] !== dfn(32'h1000 + 32'(4*i))) begin fails++; $display("FAIL stream_data[%0d]: got %h want %h", i, dat_log[i], dfn(32'h1000 + 32'(4*i))); end
    end
  endtask

  task automatic test_stall();
    lat = 1;
    do_reset(32'h1000);
    pipe_stall = 1;
    repeat (10) @(negedge clk);
    #1;
    tests++; if (req_log.size() != 4) begin fails++; $display("FAIL stall_req_count: got %0d want 4", req_log.size()); end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_instr_valid: got %b want 1", instr_valid); end
    tests++; if (addr_valid !== 1'b0) begin fails++; $display("FAIL stall_addr_valid: got %b want 0", addr_valid); end
    tests++; if (instr_tag !== 32'h1000) begin fails++; $display("FAIL stall_head_tag: got %h want 00001000", instr_tag); end
    tests++; if (instr !== dfn(32'h1000)) begin fails++; $display("FAIL stall_head_data: got %h want %h", instr, dfn(32'h1000)); end
    pipe_stall = 0;
    #1;
    tests++; if (addr_valid !== 1'b0) begin fails++; $display("FAIL stall_release_full: got %b want 0", addr_valid); end
    @(negedge clk);
    #1;
    tests++; if (addr_valid !== 1'b1) begin fails++; $display("FAIL stall_resume_valid: got %b want 1", addr_valid); end
    tests++; if (tag_out !== 32'h1010) begin fails++; $display("FAIL stall_resume_tag: got %h want 00001010", tag_out); end
    tests++; if (out_log[0] !== 32'h1000) begin fails++; $display("FAIL stall_first_pop: got %h want 00001000", out_log[0]); end
  endtask

  task automatic test_flush();
    int stale;
    lat = 5;
    do_reset(32'h1000);
    repeat (3) @(negedge clk);
    pc_exu = 32'h2000; pc_load = 1;
    #1;
    tests++; if (addr_valid !== 1'b0) begin fails++; $display("FAIL flush_no_req: got %b want 0", addr_valid); end
    @(negedge clk);
    pc_load = 0;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL flush_empty: got %b want 0", instr_valid); end
    tests++; if (addr_valid !== 1'b1 || tag_out !== 32'h2000) begin fails++; $display("FAIL flush_resume: got %b/%h want 1/00002000", addr_valid, tag_out); end
    repeat (25) @(negedge clk);
    stale = 0;
    foreach (out_log[i]) if (out_log[i] < 32'h2000) stale++;
    tests++; if (stale != 0) begin fails++; $display("FAIL flush_stale: got %0d want 0", stale); end
    tests++; if (out_log[0] !== 32'h2000) begin fails++; $display("FAIL flush_first_tag: got %h want 00002000", out_log[0]); end
    tests++; if (out_log[2] !== 32'h2008) begin fails++; $display("FAIL flush_third_tag: got %h want 00002008", out_log[2]); end
    tests++; if (req_log[3] !== 32'h2000) begin fails++; $display("FAIL flush_req: got %h want 00002000", req_log[3]); end
`ifdef IFU_PREFETCH_PERF_EN
    tests++; if (drop_count !== 32'd3) begin fails++; $display("FAIL flush_drop_count: got %0d want 3", drop_count); end
`endif
  endtask

  task automatic test_flush_pop();
    int n;
    lat = 1;
    do_reset(32'h1000);
    repeat (6) @(negedge clk);
    pc_exu = 32'h3000; pc_load = 1;
    #1;
    n = out_log.size();
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL fpop_pre_valid: got %b want 1", instr_valid); end
    tests++; if (addr_valid !== 1'b0) begin fails++; $display("FAIL fpop_no_req: got %b want 0", addr_valid); end
    @(negedge clk);
    pc_load = 0;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fpop_empty: got %b want 0", instr_valid); end
    tests++; if (addr_valid !== 1'b1 || tag_out !== 32'h3000) begin fails++; $display("FAIL fpop_resume: got %b/%h want 1/00003000", addr_valid, tag_out); end
    repeat (6) @(negedge clk);
    tests++; if (out_log[n] !== 32'h3000) begin fails++; $display("FAIL fpop_first_tag: got %h want 00003000", out_log[n]); end
    tests++; if (out_log[n+1] !== 32'h3004) begin fails++; $display("FAIL fpop_second_tag: got %h want 00003004", out_log[n+1]); end
`ifdef IFU_PREFETCH_PERF_EN
    tests++; if (drop_count !== 32'd1) begin fails++; $display("FAIL fpop_drop_count: got %0d want 1", drop_count); end
`endif
  endtask

  task automatic test_double_flush();
    int stale;
    lat = 6;
    do_reset(32'h1000);
    repeat (3) @(negedge clk);
    pc_exu = 32'h4000; pc_load = 1;
    @(negedge clk);
    pc_load = 0;
    @(negedge clk);
    pc_exu = 32'h5000; pc_load = 1;
    #1;
    tests++; if (addr_valid !== 1'b0) begin fails++; $display("FAIL dflush_no_req: got %b want 0", addr_valid); end
    @(negedge clk);
    pc_load = 0;
    repeat (30) @(negedge clk);
    stale = 0;
    foreach (out_log[i]) if (out_log[i] < 32'h5000) stale++;
    tests++; if (stale != 0) begin fails++; $display("FAIL dflush_stale: got %0d want 0", stale); end
    tests++; if (out_log[0] !== 32'h5000) begin fails++; $display("FAIL dflush_first_tag: got %h want 00005000", out_log[0]); end
    tests++; if (out_log[1] !== 32'h5004) begin fails++; $display("FAIL dflush_second_tag: got %h want 00005004", out_log[1]); end
    tests++; if (req_log[3] !== 32'h4000 || req_log[4] !== 32'h5000) begin fails++; $display("FAIL dflush_reqs: got %h,%h want 00004000,00005000", req_log[3], req_log[4]); end
`ifdef IFU_PREFETCH_PERF_EN
    tests++; if (drop_count !== 32'd4) begin fails++; $display("FAIL dflush_drop_count: got %0d want 4", drop_count); end
`endif
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset(32'hFFFF_FFF8);
    repeat (8) @(negedge clk);
    tests++; if (req_log[1] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_req1: got %h want fffffffc", req_log[1]); end
    tests++; if (req_log[2] !== 32'h0) begin fails++; $display("FAIL wrap_req2: got %h want 00000000", req_log[2]); end
    tests++; if (req_log[3] !== 32'h4) begin fails++; $display("FAIL wrap_req3: got %h want 00000004", req_log[3]); end
    tests++; if (out_log[2] !== 32'h0) begin fails++; $display("FAIL wrap_out2: got %h want 00000000", out_log[2]); end
  endtask

  task automatic test_mid_reset();
    lat = 1;
    do_reset(32'h1000);
    pipe_stall = 1;
    repeat (8) @(negedge clk);
    #1;
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL mreset_pre_valid: got %b want 1", instr_valid); end
    rst_n = 0;
    #1;
    tests++; if (instr_valid !== 1'b0 || addr_valid !== 1'b0) begin fails++; $display("FAIL mreset_valids: got %b/%b want 0/0", instr_valid, addr_valid); end
    tests++; if (instr !== 32'h0 || instr_tag !== 32'h0) begin fails++; $display("FAIL mreset_outputs: got %h/%h want 0/0", instr, instr_tag); end
    do_reset(32'h8000);
    repeat (4) @(negedge clk);
    tests++; if (req_log[0] !== 32'h8000) begin fails++; $display("FAIL mreset_first_req: got %h want 00008000", req_log[0]); end
    tests++; if (out_log[0] !== 32'h8000) begin fails++; $display("FAIL mreset_first_out: got %h want 00008000", out_log[0]); end
`ifdef IFU_PREFETCH_PERF_EN
    tests++; if (drop_count !== 32'd0) begin fails++; $display("FAIL mreset_drop_count: got %0d want 0", drop_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_pop();
    test_double_flush();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
